// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and constants for the three-requester memory port arbiter.
//   arb_state_t  : IDLE / BUSY / DONE controller states
//   REQ_*        : requester indices (PTW, data load/store, instruction fetch)
//   OWNER_NONE   : owner value reported when no transaction is in flight
//   PADDR_W/XLEN : physical address and data widths
//   pick_winner  : arbitration rule (PTW first, then round-robin data/fetch)
// -----------------------------------------------------------------------------
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    localparam int         NUM_REQ    = 3;
    localparam int         REQ_PTW    = 0;
    localparam int         REQ_DATA   = 1;
    localparam int         REQ_FETCH  = 2;
    localparam logic [1:0] OWNER_NONE = 2'd3;
    localparam int         PADDR_W    = 56;
    localparam int         XLEN       = 64;

    // PTW always wins. Data and fetch only compete with each other; when both
    // request, rr_fetch selects which one is currently favoured.
    function automatic logic [1:0] pick_winner(input logic [2:0] req_vec,
                                               input logic       rr_fetch);
        logic [1:0] w;
        w = OWNER_NONE;
        if (req_vec[REQ_PTW]) begin
            w = 2'(REQ_PTW);
        end else if (req_vec[REQ_DATA] && (!req_vec[REQ_FETCH] || !rr_fetch)) begin
            w = 2'(REQ_DATA);
        end else if (req_vec[REQ_FETCH]) begin
            w = 2'(REQ_FETCH);
        end
        return w;
    endfunction

endpackage

// File: rtl/mem_arb_watchdog.sv
// -----------------------------------------------------------------------------
// mem_arb_watchdog
// Counts cycles spent waiting for a memory response and flags expiry.
// Only built when the arbiter is compiled with ARB_TIMEOUT_EN.
//   phi2    in  clock
//   rst     in  synchronous active-high reset
//   clear   in  restart the count (asserted on the cycle a grant is made)
//   run     in  count enable (high while the arbiter is in BUSY)
//   expired out high during the TIMEOUT_CYCLES-th consecutive run cycle
// -----------------------------------------------------------------------------
module mem_arb_watchdog #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic phi2,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] count_reg;

    // count_reg is 0 in the first BUSY cycle, so expiry lands exactly on the
    // TIMEOUT_CYCLES-th BUSY cycle.
    assign expired = run && (count_reg == LAST_COUNT);

    always_ff @(posedge phi2) begin
        if (rst || clear) begin
            count_reg <= 8'd0;
        end else if (run && !expired) begin
            count_reg <= count_reg + 8'd1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Arbitrates one memory port between the page-table walker, the data
// load/store unit and the instruction fetch unit. One transaction at a time:
// IDLE (arbitrate + latch) -> BUSY (strobe memory) -> DONE (ack pulse).
//
// Optional feature: define ARB_TIMEOUT_EN to build a BUSY watchdog that ends a
// stuck transaction after TIMEOUT_CYCLES with ack+err and rdata=0. Without it,
// BUSY waits for mem_ready indefinitely and err is constant zero.
//
// Ports:
//   phi2          in   clock, all state on rising edge
//   rst           in   synchronous active-high reset
//   req[2:0]      in   requests: bit0 PTW, bit1 data, bit2 fetch
//   req_we[2:0]   in   per-requester write enable
//   req_addr[3]   in   per-requester physical address (56b)
//   req_wdata[3]  in   per-requester write data (64b)
//   ack[2:0]      out  one-hot completion pulse to the owner
//   err[2:0]      out  one-hot timeout pulse, coincident with ack
//   rdata         out  read data, valid in the ack cycle
//   owner         out  current owner index, 3 when idle
//   mem_read_rq   out  memory read strobe
//   mem_write_rq  out  memory write strobe
//   mem_addr      out  latched address
//   mem_wdata     out  latched write data
//   mem_rdata     in   memory read data
//   mem_ready     in   memory completion, qualifies mem_rdata
// -----------------------------------------------------------------------------
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic               phi2,
    input  logic               rst,
    input  logic [2:0]         req,
    input  logic [2:0]         req_we,
    input  logic [PADDR_W-1:0] req_addr [NUM_REQ],
    input  logic [XLEN-1:0]    req_wdata [NUM_REQ],
    output logic [2:0]         ack,
    output logic [2:0]         err,
    output logic [XLEN-1:0]    rdata,
    output logic [1:0]         owner,
    output logic               mem_read_rq,
    output logic               mem_write_rq,
    output logic [PADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]    mem_wdata,
    input  logic [XLEN-1:0]    mem_rdata,
    input  logic               mem_ready
);

    arb_state_t         state_reg;
    logic [1:0]         owner_reg;
    logic               rr_fetch_reg;   // 0 favours data, 1 favours fetch
    logic [2:0]         ack_reg;
    logic [XLEN-1:0]    rdata_reg;
    logic               rd_rq_reg;
    logic               wr_rq_reg;
    logic [PADDR_W-1:0] addr_reg;
    logic [XLEN-1:0]    wdata_reg;

    logic [1:0]         winner;
    logic               grant;
    logic               timeout_hit;
    logic [2:0]         owner_onehot;

    assign winner = pick_winner(req, rr_fetch_reg);
    assign grant  = (state_reg == IDLE) && (req != 3'b000);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_owner_dec
            assign owner_onehot[gi] = (owner_reg == 2'(gi));
        end
    endgenerate

    // Out-of-range watchdog limits leave this named block empty; kept so the
    // limit is visibly tied to the build even when the watchdog is absent.
    generate
        if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_timeout_out_of_range
        end
    endgenerate

`ifdef ARB_TIMEOUT_EN
    logic [2:0] err_reg;

    mem_arb_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .phi2    (phi2),
        .rst     (rst),
        .clear   (grant),
        .run     (state_reg == BUSY),
        .expired (timeout_hit)
    );

    // mem_ready wins over a simultaneous expiry, matching the FSM below.
    always_ff @(posedge phi2) begin
        if (rst) begin
            err_reg <= 3'b000;
        end else if ((state_reg == BUSY) && !mem_ready && timeout_hit) begin
            err_reg <= owner_onehot;
        end else begin
            err_reg <= 3'b000;
        end
    end

    assign err = err_reg;
`else
    assign timeout_hit = 1'b0;
    assign err         = 3'b000;
`endif

    always_ff @(posedge phi2) begin
        if (rst) begin
            state_reg    <= IDLE;
            owner_reg    <= OWNER_NONE;
            rr_fetch_reg <= 1'b0;
            ack_reg      <= 3'b000;
            rdata_reg    <= '0;
            rd_rq_reg    <= 1'b0;
            wr_rq_reg    <= 1'b0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
        end else begin
            ack_reg <= 3'b000;
            case (state_reg)
                IDLE: begin
                    if (grant) begin
                        owner_reg <= winner;
                        addr_reg  <= req_addr[winner];
                        wdata_reg <= req_wdata[winner];
                        rd_rq_reg <= !req_we[winner];
                        wr_rq_reg <= req_we[winner];
                        // PTW grants leave the data/fetch fairness untouched.
                        if (winner != 2'(REQ_PTW)) begin
                            rr_fetch_reg <= !rr_fetch_reg;
                        end
                        state_reg <= BUSY;
                    end
                end
                BUSY: begin
                    if (mem_ready) begin
                        rdata_reg <= mem_rdata;
                        rd_rq_reg <= 1'b0;
                        wr_rq_reg <= 1'b0;
                        ack_reg   <= owner_onehot;
                        state_reg <= DONE;
                    end else if (timeout_hit) begin
                        rdata_reg <= '0;
                        rd_rq_reg <= 1'b0;
                        wr_rq_reg <= 1'b0;
                        ack_reg   <= owner_onehot;
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    owner_reg <= OWNER_NONE;
                    state_reg <= IDLE;
                end
                default: begin
                    owner_reg <= OWNER_NONE;
                    rd_rq_reg <= 1'b0;
                    wr_rq_reg <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign ack          = ack_reg;
    assign rdata        = rdata_reg;
    assign owner        = owner_reg;
    assign mem_read_rq  = rd_rq_reg;
    assign mem_write_rq = wr_rq_reg;
    assign mem_addr     = addr_reg;
    assign mem_wdata    = wdata_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Scoreboard bench for mem_port_arbiter. The driver walks each transaction
// through its request / memory-wait / completion cycles, predicts the owner
// from the priority and fairness rules, and queues the expected completion.
// A separate monitor checks memory strobes and ack/err/rdata/owner against the
// head of the queue. Timeout scenario is compiled when ARB_TIMEOUT_EN is set.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int TMO = 8;

    logic        phi2 = 1'b0;
    logic        rst  = 1'b1;
    logic [2:0]  req    = 3'b000;
    logic [2:0]  req_we = 3'b000;
    logic [55:0] req_addr  [3];
    logic [63:0] req_wdata [3];
    logic [2:0]  ack;
    logic [2:0]  err;
    logic [63:0] rdata;
    logic [1:0]  owner;
    logic        mem_read_rq;
    logic        mem_write_rq;
    logic [55:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata = 64'd0;
    logic        mem_ready = 1'b0;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;
    bit mon_en = 1'b0;
    bit abort_mode = 1'b0;
    bit fav_fetch = 1'b0;   // model fairness: 0 favours data

    typedef struct {
        int          own;
        bit          we;
        logic [55:0] addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
        bit          err;
        int          ack_cyc;
    } exp_t;

    exp_t exp_q[$];

    mem_port_arbiter #(
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .phi2         (phi2),
        .rst          (rst),
        .req          (req),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .ack          (ack),
        .err          (err),
        .rdata        (rdata),
        .owner        (owner),
        .mem_read_rq  (mem_read_rq),
        .mem_write_rq (mem_write_rq),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ready    (mem_ready)
    );

    always #5 phi2 = ~phi2;

    always @(posedge phi2) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [63:0] act,
                                input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, expv, cyc);
        end
    endfunction

    // Priority: PTW first; data vs fetch by the fairness flag, which flips on
    // every data or fetch grant.
    function automatic int model_grant(input logic [2:0] r);
        int w;
        if (r[0])              w = 0;
        else if (r[1] && r[2]) w = fav_fetch ? 2 : 1;
        else if (r[1])         w = 1;
        else                   w = 2;
        if (w != 0) fav_fetch = ~fav_fetch;
        return w;
    endfunction

    task automatic rand_inputs();
        req    = 3'($urandom_range(0, 7));
        req_we = 3'($urandom);
        for (int i = 0; i < 3; i++) begin
            req_addr[i]  = 56'({$urandom, $urandom});
            req_wdata[i] = {$urandom, $urandom};
        end
    endtask

    // Called at the falling edge of an IDLE cycle with requests already driven.
    // Memory answers in BUSY cycle dly (or never, for the timeout case).
    task automatic issue(input int dly, input logic [63:0] rv,
                         input bit never_ready, input bit hold);
        exp_t e;
        int   w;
        mem_ready = 1'($urandom_range(0, 1));   // ignored outside BUSY
        mem_rdata = {$urandom, $urandom};
        if (req == 3'b000) begin
            @(negedge phi2);
            return;
        end
        w         = model_grant(req);
        e.own     = w;
        e.we      = req_we[w];
        e.addr    = req_addr[w];
        e.wdata   = req_wdata[w];
        e.err     = never_ready;
        e.rdata   = never_ready ? 64'd0 : rv;
        e.ack_cyc = cyc + dly + 1;
        exp_q.push_back(e);
        for (int b = 1; b <= dly; b++) begin
            @(negedge phi2);
            if (!hold) rand_inputs();
            mem_ready = (b == dly) && !never_ready;
            mem_rdata = (b == dly) ? rv : {$urandom, $urandom};
        end
        @(negedge phi2);                          // completion cycle
        if (!hold) rand_inputs();
        mem_ready = 1'($urandom_range(0, 1));
        mem_rdata = {$urandom, $urandom};
        @(negedge phi2);                          // back to idle
    endtask

    // Monitor: strobes against the in-flight transaction, acks against the queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge phi2);
            if (mon_en) begin
                if ((mem_read_rq || mem_write_rq) && !abort_mode) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_strobe", {mem_write_rq, mem_read_rq}, 64'd0);
                    end else begin
                        e = exp_q[0];
                        chk("strobe_dir", {mem_write_rq, mem_read_rq}, e.we ? 2'b10 : 2'b01);
                        chk("mem_addr", mem_addr, e.addr);
                        if (e.we) chk("mem_wdata", mem_wdata, e.wdata);
                        chk("busy_owner", owner, e.own);
                    end
                end
                if ((ack !== 3'b000) || (err !== 3'b000)) begin
                    if (abort_mode || exp_q.size() == 0) begin
                        chk("unexpected_ack", {err, ack}, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("ack", ack, 3'b001 << e.own);
                        chk("err", err, e.err ? (3'b001 << e.own) : 3'b000);
                        chk("ack_owner", owner, e.own);
                        chk("rdata", rdata, e.rdata);
                        chk("ack_cycle", cyc, e.ack_cyc);
                        chk("strobes_off_in_ack", {mem_write_rq, mem_read_rq}, 64'd0);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, cycle=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            req_addr[i]  = 56'd0;
            req_wdata[i] = 64'd0;
        end
        repeat (3) @(negedge phi2);

        // Reset state
        chk("rst_owner", owner, 2'd3);
        chk("rst_ack", ack, 3'b000);
        chk("rst_err", err, 3'b000);
        chk("rst_rdata", rdata, 64'd0);
        chk("rst_strobes", {mem_write_rq, mem_read_rq}, 64'd0);
        chk("rst_mem_addr", mem_addr, 56'd0);
        chk("rst_mem_wdata", mem_wdata, 64'd0);
        rst    = 1'b0;
        mon_en = 1'b1;

        // All three request at once: PTW wins, immediate memory response
        rand_inputs();
        req = 3'b111; req_we = 3'b000;
        issue(1, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b1);

        // Data and fetch held continuously: alternate data, fetch, ...
        req = 3'b110; req_we = 3'b000;
        for (int k = 0; k < 4; k++) issue(1, {$urandom, $urandom}, 1'b0, 1'b1);

        // Fetch read with a slow memory
        req = 3'b100; req_we = 3'b000; req_addr[2] = 56'h8000_1000;
        issue(5, 64'hDEAD_BEEF_CAFE_F00D, 1'b0, 1'b1);

        // Data write
        req = 3'b010; req_we = 3'b010; req_addr[1] = 56'h2000; req_wdata[1] = 64'h1234;
        issue(2, {$urandom, $urandom}, 1'b0, 1'b1);

        // Reset in the second BUSY cycle aborts without ack
        req = 3'b010; req_we = 3'b000; req_addr[1] = 56'h3000;
        void'(model_grant(req));
        abort_mode = 1'b1;
        mem_ready  = 1'b0;
        @(negedge phi2);
        @(negedge phi2);
        chk("abort_busy_strobe", mem_read_rq, 1'b1);
        rst = 1'b1;
        @(negedge phi2);
        chk("abort_strobes", {mem_write_rq, mem_read_rq}, 64'd0);
        chk("abort_owner", owner, 2'd3);
        chk("abort_ack", ack, 3'b000);
        rst = 1'b0; req = 3'b000; fav_fetch = 1'b0;
        repeat (3) @(negedge phi2);
        abort_mode = 1'b0;

`ifdef ARB_TIMEOUT_EN
        // Memory never answers: ack+err after TMO BUSY cycles, rdata zero
        rand_inputs();
        req = 3'b100; req_we = 3'b000;
        issue(TMO, 64'd0, 1'b1, 1'b1);
`endif

        // Randomized traffic
        for (int k = 0; k < 150; k++) begin
            rand_inputs();
            if ($urandom_range(0, 3) == 0) req = 3'b000;
            issue($urandom_range(1, 6), {$urandom, $urandom}, 1'b0, 1'($urandom_range(0, 1)));
        end

        req = 3'b000;
        repeat (4) @(negedge phi2);
        chk("scoreboard_drained", exp_q.size(), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
